sync_debounce: RTL

SYNC_DEBOUNCE -- requirements
Module: sync_debounce

---
 rtl/sync_debounce.sv | 77 +++++++
 1 files changed

// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - per-channel synchronizer, tick-qualified debouncer and edge pulses
module sync_debounce #(
    parameter int             N      = 1,
    parameter int             STAGES = 2,
    parameter int             DB_CNT = 4,
    parameter logic [N-1:0]   INIT   = {N{1'b0}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in,
    input  logic         tick,
    output logic [N-1:0] out,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall
);

    localparam int            CW      = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CNT - 1);

    logic [N-1:0]  r_sync [STAGES];
    logic [CW-1:0] r_cnt  [N];
    logic [CW-1:0] w_cnt_next [N];
    logic [N-1:0]  r_out;
    logic [N-1:0]  r_rise;
    logic [N-1:0]  r_fall;
    logic [N-1:0]  w_s;
    logic [N-1:0]  w_out_next;

    assign w_s  = r_sync[STAGES-1];
    assign out  = r_out;
    assign rise = r_rise;
    assign fall = r_fall;

    // Any agreeing cycle clears the count; the final qualifying tick flips out and clears it too.
    always_comb begin
        w_out_next = r_out;
        for (int i = 0; i < N; i++) begin
            w_cnt_next[i] = '0;
            if (w_s[i] != r_out[i]) begin
                if (!tick) begin
                    w_cnt_next[i] = r_cnt[i];
                end else if (r_cnt[i] == CNT_MAX) begin
                    w_out_next[i] = w_s[i];
                end else begin
                    w_cnt_next[i] = r_cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_sync[k] <= INIT;
            end
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
            r_out  <= INIT;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_sync[0] <= in;
            for (int k = 1; k < STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
            r_out  <= w_out_next;
            // Pulses are registered alongside out so they appear in its first new-value cycle.
            r_rise <= w_out_next & ~r_out;
            r_fall <= ~w_out_next & r_out;
        end
    end

endmodule
